// File: rtl/if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_inst_queue
// Purpose  : Fetch-side instruction queue between the fetch pipeline and ID.
//            Stores DEPTH 8-byte fetch packets (two instruction slots plus
//            prediction and exception info) in a circular buffer. Drains one
//            instruction per cycle and skips slots that precede the fetch PC
//            or follow a predicted-taken branch.
// Ports    : clk, rst (async, active-high), flush (sync clear)
//            in_*  : fetch packet input with valid/ready handshake
//            out_* : single-instruction output to ID with valid/ready
//            count : number of packets currently held
// Revision : 1.0  initial release
// ============================================================================
module if_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_inst0,
    input  logic [31:0]            in_inst1,
    input  logic                   in_pred_taken,
    input  logic                   in_pred_slot,
    input  logic [31:0]            in_pred_pc,
    input  logic                   in_excp,
    input  logic [6:0]             in_excp_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic                   out_pred_taken,
    output logic [31:0]            out_pred_pc,
    output logic                   out_excp,
    output logic [6:0]             out_excp_code,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Packet payload storage (not reset)
    logic [28:0] mem_pc_hi_q [DEPTH];
    logic [31:0] mem_inst0_q [DEPTH];
    logic [31:0] mem_inst1_q [DEPTH];
    logic        mem_start_q [DEPTH];
    logic        mem_end_q   [DEPTH];
    logic        mem_pt_q    [DEPTH];
    logic [31:0] mem_ppc_q   [DEPTH];
    logic        mem_excp_q  [DEPTH];
    logic [6:0]  mem_code_q  [DEPTH];

    // Control state
    logic [c_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               hs_q, hs_d;

    logic               w_push;
    logic               w_pop;
    logic               w_retire;
    logic               w_in_start;
    logic               w_in_end;
    logic               w_in_pt;
    logic [c_PTR_W-1:0] w_rptr_nx;
    logic               w_unused_pc;

    // Low PC bits are implied by the slot index and never stored.
    assign w_unused_pc = ^in_pc[1:0];

    // ------------------------------------------------------------------
    // Handshakes: in_ready depends only on the registered count.
    // ------------------------------------------------------------------
    assign in_ready  = (count_q != c_FULL);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_retire  = w_pop && (hs_q == mem_end_q[rptr_q]);
    assign w_rptr_nx = rptr_q + 1'b1;
    assign count     = count_q;

    // ------------------------------------------------------------------
    // Incoming packet slot range. An exception packet emits only its first
    // slot; a prediction on a slot before the start slot is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_start = in_pc[2];
        w_in_end   = 1'b1;
        w_in_pt    = 1'b0;
        if (in_excp) begin
            w_in_end = w_in_start;
        end else if (in_pred_taken) begin
            if (in_pred_slot >= w_in_start) begin
                w_in_end = in_pred_slot;
                w_in_pt  = 1'b1;
            end else begin
                w_in_end = w_in_start;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, count and head slot pointer
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        hs_d    = hs_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            hs_d    = 1'b0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_retire) begin
                rptr_d = w_rptr_nx;
            end
            case ({w_push, w_retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (w_retire) begin
                // New head is either an already stored packet or, when the
                // queue held only the retiring packet, the one being pushed.
                if (count_q > c_ONE) begin
                    hs_d = mem_start_q[w_rptr_nx];
                end else if (w_push) begin
                    hs_d = w_in_start;
                end else begin
                    hs_d = 1'b0;
                end
            end else if (w_pop) begin
                // Not at end slot, so hs must be 0 here.
                hs_d = 1'b1;
            end else if (w_push && (count_q == '0)) begin
                hs_d = w_in_start;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hs_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            hs_q    <= hs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_pc_hi_q[wptr_q] <= in_pc[31:3];
            mem_inst0_q[wptr_q] <= in_inst0;
            mem_inst1_q[wptr_q] <= in_inst1;
            mem_start_q[wptr_q] <= w_in_start;
            mem_end_q[wptr_q]   <= w_in_end;
            mem_pt_q[wptr_q]    <= w_in_pt;
            mem_ppc_q[wptr_q]   <= in_pred_pc;
            mem_excp_q[wptr_q]  <= in_excp;
            mem_code_q[wptr_q]  <= in_excp_code;
        end
    end

    // ------------------------------------------------------------------
    // Head-entry output muxing
    // ------------------------------------------------------------------
    assign out_pc         = {mem_pc_hi_q[rptr_q], hs_q, 2'b00};
    assign out_inst       = mem_excp_q[rptr_q] ? 32'h0 :
                            (hs_q ? mem_inst1_q[rptr_q] : mem_inst0_q[rptr_q]);
    assign out_excp       = out_valid && mem_excp_q[rptr_q];
    assign out_excp_code  = mem_code_q[rptr_q];
    // The predicted branch is always the last emitted slot of its packet.
    assign out_pred_taken = out_valid && mem_pt_q[rptr_q] && (hs_q == mem_end_q[rptr_q]);
    assign out_pred_pc    = out_pred_taken ? mem_ppc_q[rptr_q] : (out_pc + 32'd4);

endmodule
`default_nettype wire

// File: tb/tb_if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_inst_queue
// Purpose  : Self-checking bench for if_inst_queue. Directed stimulus with a
//            scoreboard of expected instructions checked as ID accepts them.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic        in_pred_taken;
    logic        in_pred_slot;
    logic [31:0] in_pred_pc;
    logic        in_excp;
    logic [6:0]  in_excp_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;
    logic [31:0] out_pred_pc;
    logic        out_excp;
    logic [6:0]  out_excp_code;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pt;
        logic [31:0] ppc;
        logic        ex;
        logic [6:0]  code;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    if_inst_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_inst0      (in_inst0),
        .in_inst1      (in_inst1),
        .in_pred_taken (in_pred_taken),
        .in_pred_slot  (in_pred_slot),
        .in_pred_pc    (in_pred_pc),
        .in_excp       (in_excp),
        .in_excp_code  (in_excp_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_pred_taken(out_pred_taken),
        .out_pred_pc   (out_pred_pc),
        .out_excp      (out_excp),
        .out_excp_code (out_excp_code),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected instruction stream of one packet
    task automatic model_push(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                              input logic pt, input logic ps, input logic [31:0] ppc,
                              input logic ex, input logic [6:0] code);
        exp_t e;
        logic st;
        logic en;
        logic ptv;
        st  = pc[2];
        en  = 1'b1;
        ptv = 1'b0;
        if (ex) begin
            e.pc   = {pc[31:3], st, 2'b00};
            e.inst = 32'h0;
            e.pt   = 1'b0;
            e.ppc  = e.pc + 32'd4;
            e.ex   = 1'b1;
            e.code = code;
            sb.push_back(e);
        end else begin
            if (pt && (ps >= st)) begin
                en  = ps;
                ptv = 1'b1;
            end else if (pt) begin
                en = st;
            end
            for (int s = int'(st); s <= int'(en); s++) begin
                e.pc   = {pc[31:3], s[0], 2'b00};
                e.inst = s[0] ? i1 : i0;
                e.pt   = ptv && (s[0] == en);
                e.ppc  = e.pt ? ppc : (e.pc + 32'd4);
                e.ex   = 1'b0;
                e.code = 7'h0;
                sb.push_back(e);
            end
        end
    endtask

    // Offer a packet, wait (bounded) for acceptance, clock it in.
    task automatic push_pkt(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                            input logic pt, input logic ps, input logic [31:0] ppc,
                            input logic ex, input logic [6:0] code, input bit model);
        int n;
        n             = 0;
        in_valid      = 1'b1;
        in_pc         = pc;
        in_inst0      = i0;
        in_inst1      = i1;
        in_pred_taken = pt;
        in_pred_slot  = ps;
        in_pred_pc    = ppc;
        in_excp       = ex;
        in_excp_code  = code;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'(in_ready), 32'd1);
        if (model) model_push(pc, i0, i1, pt, ps, ppc, ex, code);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // Scoreboard checker: compare each instruction ID accepts.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_inst", out_inst, mon_e.inst);
                chk("out_pred_taken", 32'(out_pred_taken), 32'(mon_e.pt));
                chk("out_pred_pc", out_pred_pc, mon_e.ppc);
                chk("out_excp", 32'(out_excp), 32'(mon_e.ex));
                if (mon_e.ex) chk("out_excp_code", 32'(out_excp_code), 32'(mon_e.code));
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst0 = '0; in_inst1 = '0; in_pred_taken = 1'b0;
        in_pred_slot = 1'b0; in_pred_pc = '0; in_excp = 1'b0; in_excp_code = '0;
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Aligned packet, both slots
        out_ready = 1'b1;
        push_pkt(32'h1c000000, 32'h11, 32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        chk("aligned_latency_valid", 32'(out_valid), 32'd1);
        chk("aligned_count", 32'(count), 32'd1);
        wait_drain(10);

        // Unaligned packet: only slot 1, retired after one cycle
        push_pkt(32'h1c000004, 32'h33, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        chk("unaligned_count", 32'(count), 32'd1);
        step();
        chk("unaligned_retired", 32'(count), 32'd0);
        wait_drain(10);

        // Predicted taken in slot 0: slot 1 dropped
        push_pkt(32'h1c000008, 32'h55, 32'h66, 1'b1, 1'b0, 32'h1c000100, 1'b0, 7'h0, 1'b1);
        step();
        chk("pred_retired", 32'(count), 32'd0);
        wait_drain(10);

        // Fill with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_pkt(32'h1c000200 + 32'(i * 8), 32'h100 + 32'(i), 32'h200 + 32'(i),
                     1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_pc = 32'h1c000220; in_inst0 = 32'hdead; in_inst1 = 32'hbeef;
        step();
        in_valid = 1'b0;
        chk("full_5th_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        chk("full_ready_before_retire", 32'(in_ready), 32'd0);
        step();
        chk("full_ready_after_retire", 32'(in_ready), 32'd1);
        chk("full_count_after_retire", 32'(count), 32'd3);
        wait_drain(20);

        // Flush with count=3 and a packet offered in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_pkt(32'h1c000300 + 32'(i * 8), 32'h300 + 32'(i), 32'h400 + 32'(i),
                     1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b0);
        chk("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        in_valid = 1'b1; in_pc = 32'h1c000400; in_inst0 = 32'hbad0; in_inst1 = 32'hbad1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("flush_stays_empty", 32'(out_valid), 32'd0);

        // Exception packet
        push_pkt(32'h1c000000, 32'h77, 32'h88, 1'b0, 1'b0, 32'h0, 1'b1, 7'h08, 1'b1);
        wait_drain(10);

        // Single-entry queue: push of next packet while last slot retires
        push_pkt(32'h1c000014, 32'ha1, 32'ha2, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        push_pkt(32'h1c000020, 32'hb1, 32'hb2, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        chk("swap_count", 32'(count), 32'd1);
        wait_drain(10);

        // Back-to-back mixed packets
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc;
            pc = 32'h1c001000 + 32'(i * 8) + 32'($urandom_range(0, 1) * 4);
            push_pkt(pc, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 32'h1c008000 + 32'(i * 16), 1'b0, 7'h0, 1'b1);
        end
        wait_drain(60);

        // Asynchronous reset mid-drain
        out_ready = 1'b0;
        push_pkt(32'h1c000500, 32'hc1, 32'hc2, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        push_pkt(32'h1c000508, 32'hd1, 32'hd2, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1);
        out_ready = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_inst_queue.md
# if_inst_queue

Fetch-side instruction queue between the fetch stages and ID. It buffers 8-byte fetch packets (two instruction slots plus prediction/exception info) produced by the fetch pipeline. It drains them to decode one instruction per cycle, dropping slots that precede the fetch PC or follow a predicted-taken branch. It absorbs decode stalls so the PC generator and ICache can keep fetching.

## Interface
Parameters:
- DEPTH, 4, packet entries; power of two, >= 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear (branch mispredict / exception redirect).
- in_valid  in  1  fetch packet offered.
- in_ready  out  1  queue can accept a packet.
- in_pc  in  32  fetch PC; in_pc[2] selects the first valid slot.
- in_inst0  in  32  instruction at {in_pc[31:3],3'b000}.
- in_inst1  in  32  instruction at {in_pc[31:3],3'b100}.
- in_pred_taken  in  1  BTB predicted a taken branch in this packet.
- in_pred_slot  in  1  slot holding the predicted branch.
- in_pred_pc  in  32  predicted target.
- in_excp  in  1  fetch exception (ADEF/TLB) for this packet.
- in_excp_code  in  7  exception code.
- out_valid  out  1  instruction presented to ID.
- out_ready  in  1  ID accepts.
- out_pc  out  32  instruction PC.
- out_inst  out  32  instruction word.
- out_pred_taken  out  1  this instruction is the predicted-taken branch.
- out_pred_pc  out  32  in_pred_pc if out_pred_taken, else out_pc+4.
- out_excp  out  1  exception carried.
- out_excp_code  out  7  exception code.
- count  out  $clog2(DEPTH)+1  packets held.

## Operation
- Packet storage: circular buffer, wptr/rptr of $clog2(DEPTH) bits with wrap; count tracked separately.
- Valid slot range of a stored packet: start = in_pc[2]. end = in_pred_slot if in_pred_taken and in_pred_slot >= start, else 1. If in_pred_taken with in_pred_slot < start, end = start and out_pred_taken is 0 for that slot.
- Exception packet: only slot `start` is emitted, with out_excp=1 and out_inst=32'h0. end is forced to start.
- Head slot pointer `hs` (1 bit) indexes the head packet. It is loaded with the packet's start when that packet becomes head.
- Output: out_valid = (count != 0). out_pc = {pc[31:3], hs, 2'b00}. out_inst = hs ? inst1 : inst0.
- Pop: on out_valid && out_ready:
  - hs == end: the packet is retired, rptr advances, count decrements, and hs loads the next packet's start.
  - otherwise hs increments.
- Push: on in_valid && in_ready, the packet is written at wptr, wptr advances, and count increments.
- in_ready = (count != DEPTH). It is decided from the registered count only; there is no same-cycle pop bypass.
- Simultaneous push and pop of the last slot: count stays unchanged, both pointers advance, and hs loads start of the new head, or of the pushed packet if the queue becomes single-entry with it.
- flush: has priority over push and pop. Next cycle count=0, wptr=rptr=0, hs=0, out_valid=0, in_ready=1. A packet offered during the flush cycle is dropped.
- rst: asynchronous; same state as flush. Payload registers are not reset.

## Timing
- Reset values of outputs:
  - out_valid=0, in_ready=1, count=0.
  - out_pc/out_inst/out_pred_pc = value of entry 0, unspecified; the bench must not check them while out_valid=0.
  - out_pred_taken=0 and out_excp=0 are qualified by out_valid.
- Latency: a packet accepted in cycle N is visible on out_valid in cycle N+1, with no combinational in-to-out path.
- Throughput: 1 instruction/cycle. A two-slot packet occupies the head for 2 cycles.
- Full: with count=DEPTH, in_ready=0 even if out_ready=1 in that cycle. in_ready rises the cycle after a retirement.
- All outputs are driven from registers or from head-entry muxing by hs and rptr only; no dependence on in_* in the same cycle.

## Test plan
- Aligned packet (in_pc=0x1c000000, inst0=0x11, inst1=0x22, no pred) with out_ready=1 -> cycle+1: pc 0x1c000000/0x11, cycle+2: pc 0x1c000004/0x22, then out_valid=0, count returns 0.
- Unaligned packet in_pc=0x1c000004 -> single output pc 0x1c000004, inst=inst1; packet retired after 1 cycle.
- in_pc=0x1c000008, pred_taken=1, pred_slot=0, pred_pc=0x1c000100 -> one output pc 0x1c000008, out_pred_taken=1, out_pred_pc=0x1c000100; slot1 dropped.
- Fill: out_ready=0, push 5 aligned packets with DEPTH=4 -> in_ready low after the 4th, 5th not accepted, count=4. Then out_ready=1 -> 8 instructions in order, in_ready rises the cycle after the first retirement.
- flush with count=3 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1, offered packet never appears.
- Exception packet in_pc=0x1c000000, in_excp=1, code=0x08 -> one output, out_excp=1, code 0x08, pc 0x1c000000. Asserting rst mid-drain -> out_valid=0 immediately, without waiting for a clock edge.
